// File: rtl/mips_pkg.sv
// Shared constants for the text segment, IM capacity and the loader state encoding.
package mips_pkg;

  localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
  localparam int          IM_DEPTH  = 4096;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

endpackage

// File: rtl/im_loader_byte_packer.sv
// Big-endian 4-byte word assembler; word_valid fires in the same cycle as the 4th byte.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= 2'd0;
      shift <= 24'd0;
    end else if (clear) begin
      cnt   <= 2'd0;
      shift <= 24'd0;
    end else if (in_valid) begin
      cnt   <= cnt + 2'd1;
      shift <= {shift[15:0], in_byte};
    end
  end

  assign word_valid = in_valid && (cnt == 2'd3);
  assign word       = {shift, in_byte};

endmodule

// File: rtl/im_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into the instruction memory.
//   state | meaning
//   IDLE  | waiting for start, CPU released
//   LEN   | collecting 4-byte big-endian word count
//   DATA  | packing bytes into words and strobing IM writes
//   CSUM  | comparing the final byte with the running XOR
//   DONE  | image loaded and verified, CPU released
//   ERR   | bad length or checksum, CPU held in reset
module im_loader
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TEXT_BASE,
  parameter int          DEPTH     = IM_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  localparam int IW = $clog2(DEPTH + 1);

  logic [2:0]    state;
  logic [1:0]    byte_cnt;
  logic [31:0]   len;
  logic [31:0]   len_next;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic [7:0]    csum;
  logic          accept;
  logic          start_ok;
  logic          word_valid;
  logic [31:0]   word;

  assign busy     = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
  assign rx_ready = busy;
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERR);
  assign cpu_hold = busy || error;

  assign accept   = rx_valid && rx_ready;
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign len_next = {len[23:0], rx_data};
  assign idx_next = idx + 1'b1;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .in_valid   (accept && (state == ST_DATA)),
    .in_byte    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      byte_cnt <= 2'd0;
      len      <= 32'd0;
      idx      <= '0;
      csum     <= 8'd0;
      im_we    <= 1'b0;
      im_addr  <= 32'd0;
      im_wdata <= 32'd0;
    end else begin
      im_we <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state    <= ST_LEN;
            byte_cnt <= 2'd0;
            len      <= 32'd0;
            idx      <= '0;
            csum     <= 8'd0;
          end
        end
        ST_LEN: begin
          if (accept) begin
            csum     <= csum ^ rx_data;
            len      <= len_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if ((len_next == 32'd0) || (len_next > 32'(DEPTH))) state <= ST_ERR;
              else                                                 state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept) csum <= csum ^ rx_data;
          if (word_valid) begin
            im_we    <= 1'b1;
            im_wdata <= word;
            im_addr  <= BASE_ADDR + (32'(idx) << 2);
            idx      <= idx_next;
            // len was range-checked in LEN, so its low IW bits hold the full count
            if (idx_next == len[IW-1:0]) state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (accept) state <= (rx_data == csum) ? ST_DONE : ST_ERR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader with a write scoreboard checked on every IM strobe.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  im_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  logic [31:0] words_q[$];
  logic [7:0]  csum;
  int          wr_idx;
  bit          gapped;
  logic        prev_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest pending write, never back-to-back.
  always @(negedge clk) begin
    if (reset === 1'b1 && im_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_write observed=%h/%h expected=none", im_addr, im_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        assert ({im_addr, im_wdata} === e) else begin
          errors++;
          $error("FAIL write observed=%h/%h expected=%h/%h", im_addr, im_wdata, e.addr, e.data);
        end
      end
      checks++;
      assert (prev_we !== 1'b1) else begin
        errors++;
        $error("FAIL back_to_back_we observed=1 expected=0");
      end
    end
    prev_we = im_we;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (gapped) begin
      int g;
      g = $urandom_range(0, 2);
      repeat (g) @(negedge clk);
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    check("rx_ready_when_sending", {31'd0, rx_ready}, 32'd1);
    csum = csum ^ b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 3; i >= 0; i--) send_byte(n[i*8 +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    wr_t e;
    e.addr = 32'h0000_3000 + 32'(wr_idx) * 4;
    e.data = w;
    exp_q.push_back(e);
    wr_idx++;
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic begin_session();
    csum   = 8'd0;
    wr_idx = 0;
    pulse_start();
  endtask

  // Sends LEN, all of words_q and a checksum byte; optionally pulses start after word 0.
  task automatic send_frame(input bit bad_csum, input bit start_mid);
    logic [7:0] good;
    begin_session();
    send_len(32'(words_q.size()));
    for (int i = 0; i < words_q.size(); i++) begin
      send_word(words_q[i]);
      if (start_mid && i == 0) begin
        pulse_start();
        check("busy_after_mid_start", {31'd0, busy}, 32'd1);
      end
    end
    good = csum;
    send_byte(bad_csum ? 8'h00 : good);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_im_we"},    {31'd0, im_we},    32'd0);
    check({tag, "_im_addr"},  im_addr,           32'd0);
    check({tag, "_im_wdata"}, im_wdata,          32'd0);
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_done"},     {31'd0, done},     32'd0);
    check({tag, "_error"},    {31'd0, error},    32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
  endtask

  task automatic check_done();
    check("done",      {31'd0, done},     32'd1);
    check("done_err",  {31'd0, error},    32'd0);
    check("done_hold", {31'd0, cpu_hold}, 32'd0);
    check("done_busy", {31'd0, busy},     32'd0);
  endtask

  task automatic check_err();
    check("err",       {31'd0, error},    32'd1);
    check("err_done",  {31'd0, done},     32'd0);
    check("err_hold",  {31'd0, cpu_hold}, 32'd1);
    check("err_ready", {31'd0, rx_ready}, 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    gapped   = 1'b0;
    csum     = 8'd0;
    wr_idx   = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;

    // Bytes offered in IDLE are refused and change nothing.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      @(negedge clk);
      check("idle_rx_ready", {31'd0, rx_ready}, 32'd0);
      check("idle_busy",     {31'd0, busy},     32'd0);
    end
    rx_valid = 1'b0;

    // Reset in the middle of DATA.
    begin_session();
    send_len(32'd2);
    send_byte(8'h34);
    send_byte(8'h08);
    @(negedge clk);
    check("len_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    reset = 1'b1;

    // Good 2-word load.
    words_q = '{32'h3408_0005, 32'h0000_000C};
    send_frame(1'b0, 1'b0);
    check_done();
    check("hold_addr",  im_addr,  32'h0000_3004);
    check("hold_wdata", im_wdata, 32'h0000_000C);

    // Bytes offered in DONE are refused.
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h11;
    @(negedge clk);
    rx_valid = 1'b0;
    check("done_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("done_sticky",   {31'd0, done},     32'd1);

    // Bad checksum: both words still land, then ERR.
    send_frame(1'b1, 1'b0);
    check_err();

    // Length above capacity, then zero length: ERR right after the 4th LEN byte.
    begin_session();
    send_len(32'h0000_1001);
    @(negedge clk);
    check_err();
    begin_session();
    send_len(32'd0);
    @(negedge clk);
    check_err();

    // Gapped 3-word frame.
    gapped  = 1'b1;
    words_q = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF};
    send_frame(1'b0, 1'b0);
    check_done();
    gapped = 1'b0;

    // start pulsed mid-DATA is ignored.
    words_q = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    send_frame(1'b0, 1'b1);
    check_done();

    // Full-capacity image.
    words_q.delete();
    for (int i = 0; i < 4096; i++) words_q.push_back(32'(i));
    send_frame(1'b0, 1'b0);
    check_done();
    check("cap_last_addr",  im_addr,  32'h0000_6FFC);
    check("cap_last_wdata", im_wdata, 32'h0000_0FFF);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
